// File: rtl/dynamic_branch_predictor.sv
// Direct-mapped branch predictor: 2-bit saturating-counter BHT plus tagged BTB.
// Lookup is combinational from the fetch PC; updates come from the decode stage.
module dynamic_branch_predictor #(
  parameter int unsigned ENTRIES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] PC_curr,
  input  logic [15:0] IF_ID_PC_curr,
  input  logic        wen_BHT,
  input  logic        wen_BTB,
  input  logic        actual_taken,
  input  logic [15:0] actual_target,
  output logic [1:0]  prediction,
  output logic        predict_taken,
  output logic [15:0] predicted_target
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 16 - IDX_W - 1;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [15:0]      target;
  } btb_entry_t;

  logic [1:0]       bht_q [ENTRIES];
  logic [1:0]       bht_d [ENTRIES];
  btb_entry_t       btb_q [ENTRIES];
  btb_entry_t       btb_d [ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic [1:0]       cnt;
  logic             hit;

  // PC[0] is never used: instructions are halfword aligned.
  assign rd_idx = PC_curr[IDX_W:1];
  assign rd_tag = PC_curr[15:IDX_W+1];
  assign wr_idx = IF_ID_PC_curr[IDX_W:1];
  assign wr_tag = IF_ID_PC_curr[15:IDX_W+1];

  // Next-state tables: saturating counter step and BTB overwrite, independently enabled.
  always_comb begin
    bht_d = bht_q;
    btb_d = btb_q;
    cnt   = bht_q[wr_idx];
    if (wen_BHT) begin
      if (actual_taken) begin
        if (cnt != 2'b11) cnt = cnt + 2'd1;
      end else begin
        if (cnt != 2'b00) cnt = cnt - 2'd1;
      end
      bht_d[wr_idx] = cnt;
    end
    if (wen_BTB) begin
      btb_d[wr_idx].valid  = 1'b1;
      btb_d[wr_idx].tag    = wr_tag;
      btb_d[wr_idx].target = actual_target;
    end
  end

  // Table storage; asynchronous reset clears counters and invalidates the BTB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bht_q <= '{default: '0};
      btb_q <= '{default: '0};
    end else begin
      bht_q <= bht_d;
      btb_q <= btb_d;
    end
  end

  // Zero-latency lookup; reads the pre-update tables (no write bypass).
  always_comb begin
    hit              = btb_q[rd_idx].valid && (btb_q[rd_idx].tag == rd_tag);
    prediction       = bht_q[rd_idx];
    predict_taken    = hit && bht_q[rd_idx][1];
    predicted_target = hit ? btb_q[rd_idx].target : 16'h0000;
  end

endmodule

// File: tb/tb_dynamic_branch_predictor.sv
// Scoreboard bench for dynamic_branch_predictor: directed scenarios then random traffic
// checked against an array-based reference model.
module tb_dynamic_branch_predictor;

  localparam int ENTRIES = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] PC_curr;
  logic [15:0] IF_ID_PC_curr;
  logic        wen_BHT;
  logic        wen_BTB;
  logic        actual_taken;
  logic [15:0] actual_target;
  logic [1:0]  prediction;
  logic        predict_taken;
  logic [15:0] predicted_target;

  dynamic_branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .PC_curr          (PC_curr),
    .IF_ID_PC_curr    (IF_ID_PC_curr),
    .wen_BHT          (wen_BHT),
    .wen_BTB          (wen_BTB),
    .actual_taken     (actual_taken),
    .actual_target    (actual_target),
    .prediction       (prediction),
    .predict_taken    (predict_taken),
    .predicted_target (predicted_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  pred;
    logic        tk;
    logic [15:0] tgt;
    int          id;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;
  int   step_no = 0;

  // Reference model: plain integer tables indexed by arithmetic on the PC.
  int m_cnt [ENTRIES];
  bit m_val [ENTRIES];
  int m_tag [ENTRIES];
  int m_tgt [ENTRIES];

  function automatic int midx(input logic [15:0] pc);
    return (int'(pc) / 2) % ENTRIES;
  endfunction

  function automatic int mtag(input logic [15:0] pc);
    return int'(pc) / (2 * ENTRIES);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_cnt[i] = 0;
      m_val[i] = 1'b0;
      m_tag[i] = 0;
      m_tgt[i] = 0;
    end
  endtask

  task automatic chk(input string nm, input int id, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s step=%0d actual=%h required=%h", nm, id, act, exp_v);
    end
  endtask

  // One cycle of stimulus: drive inputs just after posedge, queue the expected lookup,
  // then advance the model by whatever update the DUT takes at the next edge.
  task automatic step(input logic r, input logic [15:0] pc, input logic [15:0] ifid,
                      input logic wb, input logic wt, input logic at, input logic [15:0] tgt);
    exp_t e;
    int   i;
    int   j;
    bit   hit;
    rst_n         = r;
    PC_curr       = pc;
    IF_ID_PC_curr = ifid;
    wen_BHT       = wb;
    wen_BTB       = wt;
    actual_taken  = at;
    actual_target = tgt;
    if (!r) model_reset();
    i     = midx(pc);
    hit   = m_val[i] && (m_tag[i] == mtag(pc));
    e.pred = 2'(m_cnt[i]);
    e.tk   = hit && (m_cnt[i] >= 2);
    e.tgt  = hit ? 16'(m_tgt[i]) : 16'h0000;
    e.id   = step_no;
    step_no++;
    expq.push_back(e);
    @(posedge clk);
    if (rst_n) begin
      j = midx(ifid);
      if (wb) begin
        if (at) m_cnt[j] = (m_cnt[j] == 3) ? 3 : m_cnt[j] + 1;
        else    m_cnt[j] = (m_cnt[j] == 0) ? 0 : m_cnt[j] - 1;
      end
      if (wt) begin
        m_val[j] = 1'b1;
        m_tag[j] = mtag(ifid);
        m_tgt[j] = int'(tgt);
      end
    end
    #1;
  endtask

  function automatic logic [15:0] pick_pc();
    logic [15:0] pool [5];
    pool[0] = 16'h0010;
    pool[1] = 16'h0020;
    pool[2] = 16'h0004;
    pool[3] = 16'h0014;
    pool[4] = 16'($urandom);
    return pool[$urandom_range(0, 4)];
  endfunction

  // Monitor: the lookup is always presented, so compare on every falling edge with a pending entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("prediction", e.id, 16'(prediction), 16'(e.pred));
        chk("predict_taken", e.id, 16'(predict_taken), 16'(e.tk));
        chk("predicted_target", e.id, predicted_target, e.tgt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; PC_curr = '0; IF_ID_PC_curr = '0;
    wen_BHT = 1'b0; wen_BTB = 1'b0; actual_taken = 1'b0; actual_target = '0;
    model_reset();
    @(posedge clk); #1;

    // Post-reset lookup
    step(1, 16'h0010, 16'h0000, 0, 0, 0, 16'h0000);
    // Two taken training cycles with both enables, then lookup
    step(1, 16'h0010, 16'h0010, 1, 1, 1, 16'h0040);
    step(1, 16'h0010, 16'h0010, 1, 1, 1, 16'h0040);
    step(1, 16'h0010, 16'h0000, 0, 0, 0, 16'h0000);
    // Saturation both directions
    for (int k = 0; k < 5; k++) step(1, 16'h0010, 16'h0010, 1, 0, 1, 16'h0000);
    step(1, 16'h0010, 16'h0000, 0, 0, 0, 16'h0000);
    for (int k = 0; k < 5; k++) step(1, 16'h0010, 16'h0010, 1, 0, 0, 16'h0000);
    step(1, 16'h0010, 16'h0000, 0, 0, 0, 16'h0000);
    // Tag mismatch on an aliasing PC
    for (int k = 0; k < 3; k++) step(1, 16'h0010, 16'h0010, 1, 1, 1, 16'h0040);
    step(1, 16'h0020, 16'h0000, 0, 0, 0, 16'h0000);
    // Same-cycle read and write at 0x0004
    step(1, 16'h0000, 16'h0004, 1, 0, 1, 16'h0000);
    step(1, 16'h0004, 16'h0004, 1, 0, 1, 16'h0000);
    step(1, 16'h0004, 16'h0000, 0, 0, 0, 16'h0000);
    // Mid-run reset with a trained entry and an active BTB write
    step(1, 16'h0010, 16'h0000, 0, 0, 0, 16'h0000);
    step(0, 16'h0010, 16'h0010, 1, 1, 1, 16'h0040);
    step(1, 16'h0010, 16'h0000, 0, 0, 0, 16'h0000);

    // Random traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      step(logic'($urandom_range(0, 39) != 0), pick_pc(), pick_pc(),
           logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 1)), 16'($urandom));
    end

    @(negedge clk); #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual=%0d required=0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
